// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader streaming a program image into cpu instruction/data memories
//
// Ports:
//   clk, arst_n                  clock and synchronous active-low reset
//   start                        one-cycle load request (ignored while busy)
//   s_valid, s_data, s_ready     32-bit image word stream
//   imem_addr/wen/ren/wdata      cpu instruction-memory external write port (byte address)
//   dmem_addr/wen/ren/wdata      cpu data-memory external write port (byte address, 64-bit data)
//   cpu_enable, busy, done, error  run control and load status
module program_loader #(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic [63:0] imem_addr,
    output logic        imem_wen,
    output logic        imem_ren,
    output logic [31:0] imem_wdata,
    output logic [63:0] dmem_addr,
    output logic        dmem_wen,
    output logic        dmem_ren,
    output logic [63:0] dmem_wdata,
    output logic        cpu_enable,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_INSTR, S_DATA_LO, S_DATA_HI, S_CHECK, S_RUN, S_ERROR
    } state_t;

    // 17 bits so a depth of 65536 still compares correctly against a 16-bit count
    localparam logic [16:0] IMEM_MAX = 17'(IMEM_WORDS);
    localparam logic [16:0] DMEM_MAX = 17'(DMEM_WORDS);

    state_t      state_q, state_d;
    logic [15:0] icount_q, icount_d;
    logic [15:0] dcount_q, dcount_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] didx_q, didx_d;
    logic [31:0] csum_q, csum_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] imem_addr_q, imem_addr_d;
    logic        imem_wen_q, imem_wen_d;
    logic [31:0] imem_wdata_q, imem_wdata_d;
    logic [63:0] dmem_addr_q, dmem_addr_d;
    logic        dmem_wen_q, dmem_wen_d;
    logic [63:0] dmem_wdata_q, dmem_wdata_d;
    logic        accept;

    assign s_ready = (state_q == S_HEADER) || (state_q == S_INSTR) ||
                     (state_q == S_DATA_LO) || (state_q == S_DATA_HI) ||
                     (state_q == S_CHECK);
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d      = state_q;
        icount_d     = icount_q;
        dcount_d     = dcount_q;
        idx_d        = idx_q;
        didx_d       = didx_q;
        csum_d       = csum_q;
        lo_d         = lo_q;
        imem_addr_d  = imem_addr_q;
        imem_wen_d   = 1'b0;
        imem_wdata_d = imem_wdata_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wen_d   = 1'b0;
        dmem_wdata_d = dmem_wdata_q;

        // every accepted word except the trailer feeds the checksum
        if (accept && state_q != S_CHECK) begin
            csum_d = csum_q ^ s_data;
        end

        case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
                if (start) begin
                    state_d = S_HEADER;
                    csum_d  = '0;
                    idx_d   = '0;
                    didx_d  = '0;
                end
            end
            S_HEADER: begin
                if (accept) begin
                    icount_d = s_data[15:0];
                    dcount_d = s_data[31:16];
                    if (s_data[15:0] == 16'd0 ||
                        {1'b0, s_data[15:0]} > IMEM_MAX ||
                        {1'b0, s_data[31:16]} > DMEM_MAX) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_INSTR;
                    end
                end
            end
            S_INSTR: begin
                if (accept) begin
                    imem_addr_d  = {46'd0, idx_q, 2'b00};
                    imem_wdata_d = s_data;
                    imem_wen_d   = 1'b1;
                    idx_d        = idx_q + 16'd1;
                    if (idx_q == icount_q - 16'd1) begin
                        state_d = (dcount_q == 16'd0) ? S_CHECK : S_DATA_LO;
                    end
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    lo_d    = s_data;
                    state_d = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    dmem_addr_d  = {45'd0, didx_q, 3'b000};
                    dmem_wdata_d = {s_data, lo_q};
                    dmem_wen_d   = 1'b1;
                    didx_d       = didx_q + 16'd1;
                    state_d      = (didx_q == dcount_q - 16'd1) ? S_CHECK : S_DATA_LO;
                end
            end
            S_CHECK: begin
                if (accept) begin
                    state_d = (s_data == csum_q) ? S_RUN : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q      <= S_IDLE;
            icount_q     <= '0;
            dcount_q     <= '0;
            idx_q        <= '0;
            didx_q       <= '0;
            csum_q       <= '0;
            lo_q         <= '0;
            imem_addr_q  <= '0;
            imem_wen_q   <= 1'b0;
            imem_wdata_q <= '0;
            dmem_addr_q  <= '0;
            dmem_wen_q   <= 1'b0;
            dmem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            icount_q     <= icount_d;
            dcount_q     <= dcount_d;
            idx_q        <= idx_d;
            didx_q       <= didx_d;
            csum_q       <= csum_d;
            lo_q         <= lo_d;
            imem_addr_q  <= imem_addr_d;
            imem_wen_q   <= imem_wen_d;
            imem_wdata_q <= imem_wdata_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wen_q   <= dmem_wen_d;
            dmem_wdata_q <= dmem_wdata_d;
        end
    end

    assign imem_addr  = imem_addr_q;
    assign imem_wen   = imem_wen_q;
    assign imem_ren   = 1'b0;
    assign imem_wdata = imem_wdata_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wen   = dmem_wen_q;
    assign dmem_ren   = 1'b0;
    assign dmem_wdata = dmem_wdata_q;
    assign cpu_enable = (state_q == S_RUN);
    assign done       = (state_q == S_RUN);
    assign error      = (state_q == S_ERROR);
    assign busy       = s_ready;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time loader that sits directly upstream of the cpu top.
- Consumes a 32-bit valid/ready word stream carrying a program image: header, instruction words, data words, then a checksum trailer.
- Drives the cpu's external instruction-memory and data-memory write ports, then raises the cpu enable.
- Holds the cpu disabled throughout loading and on any image error.

Parameters:
- IMEM_WORDS, 512, instruction memory depth in 32-bit words; maximum accepted instruction count.
- DMEM_WORDS, 1024, data memory depth in 64-bit words; maximum accepted data count.

Ports:
- clk  input  1  main clock
- arst_n  input  1  reset; synchronous, active-low
- start  input  1  one-cycle load request
- s_valid  input  1  stream word valid
- s_data  input  32  stream word
- s_ready  output  1  loader accepts s_data this cycle
- imem_addr  output  64  to cpu addr_ext, byte address
- imem_wen  output  1  to cpu wen_ext
- imem_ren  output  1  to cpu ren_ext, constant 0
- imem_wdata  output  32  to cpu wdata_ext
- dmem_addr  output  64  to cpu addr_ext_2, byte address
- dmem_wen  output  1  to cpu wen_ext_2
- dmem_ren  output  1  to cpu ren_ext_2, constant 0
- dmem_wdata  output  64  to cpu wdata_ext_2
- cpu_enable  output  1  to cpu enable
- busy  output  1  load in progress
- done  output  1  image accepted; cpu running
- error  output  1  image rejected

Behaviour:
- Reset: arst_n=0 sampled at a clk edge puts the FSM in IDLE.
  - All outputs go to 0, including all counters, addresses and the checksum register.
  - Reset mid-load aborts the load. Already-written memory locations are not cleared.
- Handshake: a word is accepted when s_valid && s_ready at the clk edge. s_ready is 1 in HEADER, INSTR, DATA_LO, DATA_HI and CHECK, and 0 in every other state. Memories accept a write every cycle, so the loader never back-pressures inside a load state.
- Checksum register: cleared on entry to HEADER. XOR-accumulates every accepted word except the trailer.
- FSM states and transitions:
  - IDLE: start -> HEADER.
  - HEADER: on accept, icount=s_data[15:0] and dcount=s_data[31:16].
    - icount==0, icount>IMEM_WORDS or dcount>DMEM_WORDS -> ERROR.
    - Otherwise -> INSTR.
  - INSTR: each accepted word k (k=0..icount-1) produces, on the next cycle, a one-cycle imem_wen=1 with imem_addr=4*k and imem_wdata=word. After word icount-1: dcount==0 -> CHECK, else -> DATA_LO.
  - DATA_LO: accepted word is latched as bits [31:0] -> DATA_HI.
  - DATA_HI: accepted word is bits [63:32]. Next cycle: one-cycle dmem_wen=1 with dmem_addr=8*j and dmem_wdata={hi,lo}. After data word dcount-1 -> CHECK, else -> DATA_LO.
  - CHECK: accepted trailer == checksum -> RUN; mismatch -> ERROR.
  - RUN: cpu_enable=1 and done=1, starting the cycle after trailer acceptance. start -> HEADER; cpu_enable and done drop in that same transition.
  - ERROR: error=1 and cpu_enable=0. start -> HEADER, clearing error.
- busy=1 in HEADER..CHECK. start is ignored while busy.
- Write latency: the write pulse appears exactly 1 cycle after word acceptance. All memory-side outputs are registered. Address and data hold their last value when wen=0.
- Gaps (s_valid=0) stall the FSM without side effects; no wen is asserted on stall cycles.
- Counters are 16-bit. Addresses are zero-extended to 64 bits. No wrap occurs because counts are bounded by the parameters before loading starts.

Test Plan:
- Nominal load:
  - Stimulus: start, then stream 0x00010002, 0x00500093, 0x00A00113, 0x11111111, 0x22222222, 0x33C232B1 on consecutive cycles.
  - Required: imem writes (addr 0, 0x00500093) and (addr 4, 0x00A00113); dmem write (addr 0, 0x2222222211111111); cpu_enable=1 and done=1 one cycle after the trailer, with error=0.
- Bad checksum:
  - Stimulus: same image with trailer 0x33C232B0.
  - Required: error=1, cpu_enable stays 0, s_ready=0.
  - Follow-up: a subsequent start with the correct image reaches RUN and error clears.
- Oversize header:
  - Stimulus: header 0x00000201 (icount=513).
  - Required: ERROR the cycle after the header; no imem_wen pulse ever asserted.
- Stalled stream:
  - Stimulus: the nominal image with s_valid=0 for 3 cycles between each word.
  - Required: identical write sequence, addresses and final state as the nominal load; wen never asserted on stall cycles.
- Reset mid-operation:
  - Stimulus: arst_n=0 for one cycle after the first instruction word is accepted.
  - Required: next cycle IDLE with all outputs 0; a restarted load completes normally.
- Zero data / reload:
  - Stimulus: header 0x00000001, instruction 0x00000013, trailer 0x00000012.
  - Required: RUN with no dmem_wen.
  - Follow-up: start while in RUN drops cpu_enable the next cycle and busy=1.
